// File: rtl/piso_frame_tx.sv
// Framed parallel-in/serial-out transmitter: start bit, WIDTH data bits,
// optional even-parity bit and stop bit, each held CLKS_PER_BIT clocks.
module piso_frame_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int MSB_FIRST    = 0,
  parameter int PARITY_EN    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state_q, state_n;
  logic [CW-1:0]    cyc_q, cyc_n;
  logic [BW-1:0]    bit_q, bit_n;
  logic [WIDTH-1:0] data_q, data_n;
  logic             sout_n, busy_n, done_n;
  logic             bit_end;

  // Selects the idx-th data bit in transmission order.
  function automatic logic data_bit(input logic [WIDTH-1:0] d, input logic [BW-1:0] idx);
    logic [WIDTH-1:0] sh;
    if (MSB_FIRST != 0) begin
      sh = d << idx;
      return sh[WIDTH-1];
    end else begin
      sh = d >> idx;
      return sh[0];
    end
  endfunction

  assign in_ready = (state_q == IDLE);
  assign bit_end  = (cyc_q == CYC_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      sout    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_n;
      cyc_q   <= cyc_n;
      bit_q   <= bit_n;
      data_q  <= data_n;
      sout    <= sout_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  // Outputs are computed as next-state values so each one changes on the
  // same edge that enters the state it belongs to.
  always_comb begin
    state_n = state_q;
    cyc_n   = bit_end ? '0 : cyc_q + 1'b1;
    bit_n   = bit_q;
    data_n  = data_q;
    sout_n  = sout;
    busy_n  = busy;
    done_n  = 1'b0;

    unique case (state_q)
      IDLE: begin
        cyc_n  = '0;
        bit_n  = '0;
        sout_n = 1'b1;
        busy_n = 1'b0;
        if (in_valid) begin
          data_n  = in_data;
          state_n = START;
          sout_n  = 1'b0;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          sout_n  = data_bit(data_q, '0);
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_LAST) begin
            if (PARITY_EN != 0) begin
              state_n = PARITY;
              sout_n  = ^data_q;
            end else begin
              state_n = STOP;
              sout_n  = 1'b1;
            end
          end else begin
            bit_n  = bit_q + 1'b1;
            sout_n = data_bit(data_q, bit_q + 1'b1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          sout_n  = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_n = IDLE;
          sout_n  = 1'b1;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        sout_n  = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule
